apb_syscfg_regs_mc: RTL
=======================

Name: apb_syscfg_regs_mc

Overview:
Parametrised APB system-configuration register block for NUM_CORES core complexes. Each core gets a boot-address register and a reset-control register. Reset control has two parts: a software-held reset level and a self-timed reset pulse. A global sticky lock freezes the boot addresses, and error signalling covers illegal accesses. The block sits on the peripheral APB bus and drives the boot-vector and reset inputs of each core complex.

Parameters:
APB_ADDR_WIDTH, 12, APB address width; legal range 12..32.
NUM_CORES, 2, number of core complexes; legal range 1..15.
BOOT_RESET, 32'h0000_0000, reset value of every boot-address register; bits[1:0] must be 0.
RST_PULSE_CYCLES, 16, length in PCLK cycles of a software-triggered reset pulse; legal range 1..255.

Ports:
PCLK  in  1  APB clock; the block's only clock.
PRESET  in  1  synchronous, active-high reset.
PADDR  in  APB_ADDR_WIDTH  APB address (byte address).
PWDATA  in  32  APB write data.
PWRITE  in  1  APB write (1) / read (0).
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PRDATA  out  32  APB read data.
PREADY  out  1  APB ready.
PSLVERR  out  1  APB error.
cfg_boot  out  NUM_CORES*32  boot address of core i, in slice [32*i+31:32*i].
cfg_rst  out  NUM_CORES  effective reset of core i; active-high.

Behaviour:
- Clock and reset: one clock, PCLK. PRESET is synchronous and active-high; all state updates on the PCLK rising edge with PRESET=1.
- Reset values:
  - boot[i] = BOOT_RESET.
  - rst_level[i] = 1, so cfg_rst = all ones out of reset.
  - Pulse counters = 0; per-core FSM = IDLE.
  - lock = 0.
  - PRDATA = 0; PSLVERR = 0.
- Access decoding:
  - Access phase: acc = PSEL & PENABLE. wr = acc & PWRITE; rd = acc & ~PWRITE.
  - PREADY is constant 1 (zero wait states).
  - PADDR bits above [11:0] are ignored.
- Address map:
  - Per-core block at base 16*i, i = PADDR[11:4].
  - +0x0 BOOT: RW, 32 bit. Bits[1:0] read 0 and ignore writes.
  - +0x4 RST: bit0 = rst_level, RW. bit1 = PULSE, write-1-to-trigger, reads 0. Other bits read 0.
  - +0x8 STATUS: RO. bit0 = cfg_rst[i]; bit1 = pulse busy.
  - 0xF00 LOCK: bit0 is sticky. Writing 1 sets it; writing 0 has no effect; only PRESET clears it.
  - 0xF04 INFO: RO. [7:0] = NUM_CORES; [15:8] = RST_PULSE_CYCLES.
- PSLVERR: combinational, asserted only during acc, in any of these cases:
  - PADDR[1:0] != 0;
  - unmapped address, including core index >= NUM_CORES or offset 0xC;
  - a write to STATUS or INFO;
  - a write to BOOT while lock=1.
- An access flagged with PSLVERR has no side effect. An erroring read returns PRDATA = 0.
- Read path: PRDATA is combinational and equals the register value during rd, otherwise 0.
- Write timing: register updates take effect on the edge that ends the access phase. Outputs reflect the new value the next cycle (1-cycle latency).
- Per-core pulse FSM:
  - IDLE: a write to RST with PWDATA[1]=1 loads cnt = RST_PULSE_CYCLES and moves to PULSE.
  - PULSE: cnt decrements each cycle and the FSM returns to IDLE when cnt reaches 1 and decrements. cfg_rst[i] is therefore high for exactly RST_PULSE_CYCLES cycles, starting the cycle after the write.
  - Retrigger during PULSE: cnt reloads to RST_PULSE_CYCLES, extending the pulse with no gap.
- Effective reset: cfg_rst[i] = rst_level[i] | (state==PULSE), registered; no combinational path from APB to cfg_rst.
- Simultaneous RST write: rst_level takes PWDATA[0] in the same write that triggers the pulse. Example: PWDATA=0x2 releases the level and starts a pulse; cfg_rst drops once the pulse ends.
- Independence: cores are independent; a pulse on core i does not affect core j.
- LOCK scope: lock does not protect RST. Cores can always be reset.
- PRESET mid-pulse: the FSM returns to IDLE, cnt = 0, rst_level = 1, so cfg_rst stays 1 continuously.

Test Plan:
- Reset, then read INFO and all BOOT/RST/STATUS registers -> INFO=0x0000_1002, BOOT=0, RST=1, STATUS=1, cfg_rst=2'b11.
- Write 0x8000_0003 to 0x010, then 0x0 to 0x014 -> cfg_boot[63:32]=0x8000_0000, read 0x010 = 0x8000_0000, cfg_rst=2'b01.
- With rst_level=0, write 0x2 to 0x004 -> cfg_rst[0] high exactly 16 cycles starting next cycle. Retrigger at cycle 10 -> high 26 cycles total. STATUS bit1 tracks busy.
- Write 1 to 0xF00, then 0x1234 to 0x000 -> PSLVERR=1 and BOOT unchanged. Write 0 to 0xF00 -> lock still 1. RST writes still succeed.
- Access 0x020 (NUM_CORES=2), 0x00C, 0x002, a write to 0x008 and a write to 0xF04 -> PSLVERR=1 each time, no state change, reads return 0.
- Assert PRESET at cycle 5 of an active pulse -> cfg_rst stays 1, STATUS bit1=0 after reset, all registers back to reset values.

Source files
------------

// File: rtl/apb_syscfg_regs_mc.sv
// APB system-configuration registers for NUM_CORES core complexes.
// Each core has a boot address and a reset control made of a held
// software level plus a self-timed pulse. A sticky global lock freezes
// the boot addresses; illegal accesses are answered with PSLVERR.
module apb_syscfg_regs_mc #(
  parameter int          APB_ADDR_WIDTH   = 12,
  parameter int          NUM_CORES        = 2,
  parameter logic [31:0] BOOT_RESET       = 32'h0000_0000,
  parameter int          RST_PULSE_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [NUM_CORES*32-1:0]   cfg_boot,
  output logic [NUM_CORES-1:0]      cfg_rst
);

  typedef enum logic {S_IDLE, S_PULSE} state_t;

  localparam logic [7:0] PULSE_LEN = 8'(RST_PULSE_CYCLES);
  localparam logic [7:0] NCORES_B  = 8'(NUM_CORES);

  // Only the low 12 address bits are decoded.
  logic [11:0] a;
  logic [7:0]  idx;
  logic [1:0]  off;
  assign a   = PADDR[11:0];
  assign idx = a[11:4];
  assign off = a[3:2];

  if (APB_ADDR_WIDTH > 12) begin : g_addr_hi
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^PADDR[APB_ADDR_WIDTH-1:12];
  end

  logic acc, wr, rd;
  assign acc = PSEL & PENABLE;
  assign wr  = acc & PWRITE;
  assign rd  = acc & ~PWRITE;

  logic core_hit, is_boot, is_rst, is_stat, is_lock, is_info, mapped;
  logic lock, err, ok_wr;

  assign core_hit = (idx < NCORES_B);
  assign is_boot  = core_hit & (off == 2'd0);
  assign is_rst   = core_hit & (off == 2'd1);
  assign is_stat  = core_hit & (off == 2'd2);
  assign is_lock  = (a == 12'hF00);
  assign is_info  = (a == 12'hF04);
  assign mapped   = is_boot | is_rst | is_stat | is_lock | is_info;

  assign err = acc & ((a[1:0] != 2'b00) | ~mapped |
                      (PWRITE & (is_stat | is_info)) |
                      (PWRITE & is_boot & lock));

  // Erroring accesses must have no side effect, so every write is gated here.
  assign ok_wr   = wr & ~err;
  assign PSLVERR = err;
  assign PREADY  = 1'b1;

  logic [NUM_CORES*32-1:0] boot_all;
  logic [NUM_CORES-1:0]    level_all;
  logic [NUM_CORES-1:0]    busy_all;

  assign cfg_boot = boot_all;

  // Sticky lock: set by writing 1, cleared only by PRESET.
  always_ff @(posedge PCLK) begin
    if (PRESET)                          lock <= 1'b0;
    else if (ok_wr && is_lock && PWDATA[0]) lock <= 1'b1;
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic        sel, boot_we, rst_we, trig, level, level_n, rst_q;
    logic [31:0] boot;
    logic [7:0]  cnt, cnt_n;
    state_t      state, state_n;

    assign sel     = core_hit & (idx == 8'(i));
    assign boot_we = ok_wr & sel & is_boot;
    assign rst_we  = ok_wr & sel & is_rst;
    assign trig    = rst_we & PWDATA[1];
    assign level_n = rst_we ? PWDATA[0] : level;

    // Boot address register; the two low bits are hard-wired to zero.
    always_ff @(posedge PCLK) begin
      if (PRESET)       boot <= {BOOT_RESET[31:2], 2'b00};
      else if (boot_we) boot <= {PWDATA[31:2], 2'b00};
    end

    // Software-held reset level.
    always_ff @(posedge PCLK) begin
      if (PRESET) level <= 1'b1;
      else        level <= level_n;
    end

    // Pulse FSM state and down-counter.
    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        state <= S_IDLE;
        cnt   <= 8'd0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    end

    // Pulse FSM next state: a trigger always reloads, so retriggers extend seamlessly.
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
        S_IDLE: begin
          if (trig) begin
            state_n = S_PULSE;
            cnt_n   = PULSE_LEN;
          end
        end
        S_PULSE: begin
          if (trig) begin
            cnt_n = PULSE_LEN;
          end else if (cnt == 8'd1) begin
            state_n = S_IDLE;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = 8'd0;
        end
      endcase
    end

    // Registered effective reset, built from next-state values so it
    // lines up with the level/FSM registers and has no path from APB.
    always_ff @(posedge PCLK) begin
      if (PRESET) rst_q <= 1'b1;
      else        rst_q <= level_n | (state_n == S_PULSE);
    end

    assign boot_all[32*i +: 32] = boot;
    assign level_all[i]         = level;
    assign busy_all[i]          = (state == S_PULSE);
    assign cfg_rst[i]           = rst_q;
  end

  // Combinational read mux; zero outside a legal read.
  always_comb begin
    PRDATA = 32'h0;
    if (rd && !err) begin
      if (is_lock) begin
        PRDATA = {31'h0, lock};
      end else if (is_info) begin
        PRDATA = {16'h0, PULSE_LEN, NCORES_B};
      end else begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (idx == 8'(i)) begin
            case (off)
              2'd0:    PRDATA = boot_all[32*i +: 32];
              2'd1:    PRDATA = {31'h0, level_all[i]};
              2'd2:    PRDATA = {30'h0, busy_all[i], cfg_rst[i]};
              default: PRDATA = 32'h0;
            endcase
          end
        end
      end
    end
  end

endmodule
